// File: rtl/ifmap_row_tagger.sv
// Source-to-IFMap-buffer feeder: tags each activation with row first/last flags,
// issues the job-start buffer clear and absorbs buffer backpressure in one output register.
module ifmap_row_tagger #(
  parameter int IFMap_WIDTH = 16,
  parameter int LEN_WIDTH   = 8,
  parameter int ROWS_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   row_len,
  input  logic [ROWS_WIDTH-1:0]  num_rows,
  input  logic [IFMap_WIDTH-1:0] src_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic                   IF_buff_ready,
  output logic                   IF_buff_wen,
  output logic                   IF_buff_clr,
  output logic [IFMap_WIDTH+1:0] IFMap,
  output logic                   busy,
  output logic                   done
);

  localparam int OUT_WIDTH = IFMap_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [LEN_WIDTH-1:0]   len_r;
  logic [LEN_WIDTH-1:0]   len_s;
  logic [ROWS_WIDTH-1:0]  rows_r;
  logic [ROWS_WIDTH-1:0]  rows_s;
  logic [LEN_WIDTH-1:0]   col_r;
  logic [LEN_WIDTH-1:0]   col_s;
  logic [ROWS_WIDTH-1:0]  row_r;
  logic [ROWS_WIDTH-1:0]  row_s;
  logic                   out_valid_r;
  logic                   out_valid_s;
  logic [OUT_WIDTH-1:0]   out_word_r;
  logic [OUT_WIDTH-1:0]   out_word_s;
  logic                   busy_r;
  logic                   busy_s;
  logic                   clr_r;
  logic                   clr_s;
  logic                   done_r;
  logic                   done_s;

  logic                   src_ready_s;
  logic                   accept_s;
  logic                   drain_s;
  logic                   col_first_s;
  logic                   col_last_s;
  logic                   row_last_s;

  // The source may only be accepted while streaming and the output slot is free or emptying.
  assign src_ready_s = (state_r == STREAM) && (!out_valid_r || IF_buff_ready);
  assign accept_s    = src_valid && src_ready_s;
  assign drain_s     = out_valid_r && IF_buff_ready;
  assign col_first_s = (col_r == {LEN_WIDTH{1'b0}});
  assign col_last_s  = (col_r == (len_r - LEN_WIDTH'(1'b1)));
  assign row_last_s  = (row_r == (rows_r - ROWS_WIDTH'(1'b1)));

  // Next-state, job-parameter, counter and output-register logic.
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    rows_s     = rows_r;
    col_s      = col_r;
    row_s      = row_r;
    out_word_s = out_word_r;
    if (drain_s) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end

    case (state_r)
      IDLE: begin
        if (start) begin
          len_s  = row_len;
          rows_s = num_rows;
          col_s  = {LEN_WIDTH{1'b0}};
          row_s  = {ROWS_WIDTH{1'b0}};
          // A degenerate job completes without touching the buffer.
          if ((row_len == {LEN_WIDTH{1'b0}}) || (num_rows == {ROWS_WIDTH{1'b0}})) begin
            state_s = DONE;
          end else begin
            state_s = CLR;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CLR: begin
        state_s = STREAM;
      end
      STREAM: begin
        if (accept_s) begin
          out_valid_s = 1'b1;
          out_word_s  = {col_first_s, col_last_s, src_data};
          if (col_last_s) begin
            col_s = {LEN_WIDTH{1'b0}};
            row_s = row_r + ROWS_WIDTH'(1'b1);
            if (row_last_s) begin
              state_s = DRAIN;
            end else begin
              state_s = STREAM;
            end
          end else begin
            col_s   = col_r + LEN_WIDTH'(1'b1);
            row_s   = row_r;
            state_s = STREAM;
          end
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        if (drain_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s == CLR) || (state_s == STREAM) || (state_s == DRAIN);
    clr_s  = (state_s == CLR);
    done_s = (state_s == DONE);
  end

  // State, counters and registered outputs; reset discards any pending word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      len_r       <= {LEN_WIDTH{1'b0}};
      rows_r      <= {ROWS_WIDTH{1'b0}};
      col_r       <= {LEN_WIDTH{1'b0}};
      row_r       <= {ROWS_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_word_r  <= {OUT_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      clr_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      rows_r      <= rows_s;
      col_r       <= col_s;
      row_r       <= row_s;
      out_valid_r <= out_valid_s;
      out_word_r  <= out_word_s;
      busy_r      <= busy_s;
      clr_r       <= clr_s;
      done_r      <= done_s;
    end
  end

  assign src_ready   = src_ready_s;
  assign IF_buff_wen = out_valid_r;
  assign IF_buff_clr = clr_r;
  assign IFMap       = out_word_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_ifmap_row_tagger.sv
// Self-checking bench for ifmap_row_tagger: table-driven jobs, randomized jobs against
// a queue-based tagging model, plus reset and mid-job reset sequences.
module tb_ifmap_row_tagger;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  row_len;
  logic [7:0]  num_rows;
  logic [15:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        IF_buff_ready;
  logic        IF_buff_wen;
  logic        IF_buff_clr;
  logic [17:0] IFMap;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ifmap_row_tagger #(.IFMap_WIDTH(16), .LEN_WIDTH(8), .ROWS_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .row_len(row_len), .num_rows(num_rows),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .IF_buff_ready(IF_buff_ready), .IF_buff_wen(IF_buff_wen), .IF_buff_clr(IF_buff_clr),
    .IFMap(IFMap), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] src_q[$];
  logic [17:0] got_q[$];
  int          clr_cnt;

  typedef struct {
    int         len;
    int         rows;
    int         rmode;      // 0: always ready, 1: 1,0,0 pattern, 2: random
    int         vmode;      // 0: always valid, 1: random
    bit         inj;        // pulse start mid-job
    int         dsel;       // 0: random data, 1: plan stream, 2: 5,6,7
    int         exp_words;
    int         exp_clr;
    logic [1:0] exp_first_tag;
    logic [1:0] exp_last_tag;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fill_plan();
    int plan[12] = '{-77, 95, -1, -54, 59, 6, -47, 15, -65, 30, -45, 54};
    src_q.delete();
    for (int i = 0; i < 12; i++) src_q.push_back(16'(plan[i]));
  endtask

  task automatic fill_random(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(16'($urandom));
  endtask

  task automatic run_job(input int len, input int rows, input int rmode, input int vmode,
                         input bit inj);
    logic [17:0] exp_q[$];
    logic [17:0] hold_word;
    int n, idx, cyc, first_wr, last_wr, done_cyc, done_cnt, stab_err, lat_err;
    bit done_seen, hold, want_wen, busy1, clr1, busy_at_done;
    n = len * rows;
    // Reference: element i of the flattened job sits at column i mod len.
    for (int i = 0; i < n; i++) begin
      int pos;
      pos = i % len;
      exp_q.push_back({(pos == 0), (pos == len - 1), src_q[i]});
    end
    got_q.delete();
    clr_cnt = 0; idx = 0; cyc = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
    done_cnt = 0; stab_err = 0; lat_err = 0; done_seen = 0; hold = 0; want_wen = 0;
    busy1 = 0; clr1 = 0; busy_at_done = 1'b1; hold_word = '0;
    @(negedge clk);
    start = 1'b1; row_len = 8'(len); num_rows = 8'(rows); src_valid = 1'b0; IF_buff_ready = 1'b1;
    while (!done_seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start    = (inj && cyc == 4) ? 1'b1 : 1'b0;
      row_len  = 8'($urandom_range(1, 3));
      num_rows = 8'($urandom_range(1, 3));
      if (idx < n) src_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      else         src_valid = 1'b0;
      src_data = (idx < n) ? src_q[idx] : 16'($urandom);
      case (rmode)
        0:       IF_buff_ready = 1'b1;
        1:       IF_buff_ready = ((cyc % 3) == 1);
        default: IF_buff_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (IF_buff_clr) clr_cnt++;
      if (cyc == 1) begin busy1 = busy; clr1 = IF_buff_clr; end
      if (want_wen && !IF_buff_wen) lat_err++;
      if (hold && (!IF_buff_wen || IFMap !== hold_word)) stab_err++;
      hold      = IF_buff_wen && !IF_buff_ready;
      hold_word = IFMap;
      want_wen  = src_valid && src_ready;
      if (src_valid && src_ready) idx++;
      if (IF_buff_wen && IF_buff_ready) begin
        got_q.push_back(IFMap);
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (done) begin
        done_cnt++; done_seen = 1'b1; done_cyc = cyc; busy_at_done = busy;
      end
    end
    @(negedge clk);
    start = 1'b0; src_valid = 1'b0;
    #1;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("done_seen", {63'd0, done_seen}, 64'd1);
    chk("done_count", done_cnt, 1);
    chk("busy_low_at_done", {63'd0, busy_at_done}, 64'd0);
    chk("word_count", got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk("word", got_q[i], exp_q[i]);
    chk("hold_stable", stab_err, 0);
    chk("load_latency", lat_err, 0);
    chk("src_consumed", idx, n);
    if (n > 0) begin
      chk("clr_count", clr_cnt, 1);
      chk("clr_first_cycle", {63'd0, clr1}, 64'd1);
      chk("busy_first_cycle", {63'd0, busy1}, 64'd1);
      chk("done_after_last_write", done_cyc, last_wr + 1);
      if (rmode == 0 && vmode == 0) begin
        chk("first_write_cycle", first_wr, 3);
        chk("back_to_back", last_wr - first_wr, n - 1);
      end
    end else begin
      chk("zero_no_clr", clr_cnt, 0);
      chk("zero_done_cycle", done_cyc, 1);
      chk("zero_busy", {63'd0, busy1}, 64'd0);
    end
  endtask

  initial begin
    vec_t vecs[7];
    logic [1:0] tags32[6] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
    int wr;

    vecs[0] = '{12, 1, 0, 0, 1'b0, 1, 12, 1, 2'b10, 2'b01};
    vecs[1] = '{12, 1, 1, 0, 1'b0, 1, 12, 1, 2'b10, 2'b01};
    vecs[2] = '{1,  3, 0, 0, 1'b0, 2, 3,  1, 2'b11, 2'b11};
    vecs[3] = '{3,  2, 0, 1, 1'b0, 0, 6,  1, 2'b10, 2'b01};
    vecs[4] = '{0,  5, 0, 0, 1'b0, 0, 0,  0, 2'b00, 2'b00};
    vecs[5] = '{4,  3, 2, 1, 1'b1, 0, 12, 1, 2'b10, 2'b01};
    vecs[6] = '{5,  0, 0, 0, 1'b0, 0, 0,  0, 2'b00, 2'b00};

    rstn = 1'b0; start = 1'b0; row_len = '0; num_rows = '0; src_data = '0;
    src_valid = 1'b0; IF_buff_ready = 1'b0;
    repeat (2) @(negedge clk);
    IF_buff_ready = 1'b1; src_valid = 1'b1;
    #1;
    chk("reset_outputs", {src_ready, IF_buff_wen, IF_buff_clr, IFMap, busy, done}, 64'd0);
    @(negedge clk);
    rstn = 1'b1; src_valid = 1'b0;

    for (int v = 0; v < 7; v++) begin
      case (vecs[v].dsel)
        1:       fill_plan();
        2:       begin src_q.delete(); src_q.push_back(16'd5); src_q.push_back(16'd6); src_q.push_back(16'd7); end
        default: fill_random(vecs[v].len * vecs[v].rows);
      endcase
      run_job(vecs[v].len, vecs[v].rows, vecs[v].rmode, vecs[v].vmode, vecs[v].inj);
      chk("vec_words", got_q.size(), vecs[v].exp_words);
      chk("vec_clr", clr_cnt, vecs[v].exp_clr);
      if (vecs[v].exp_words > 0 && got_q.size() > 0) begin
        chk("vec_first_tag", got_q[0][17:16], vecs[v].exp_first_tag);
        chk("vec_last_tag", got_q[got_q.size()-1][17:16], vecs[v].exp_last_tag);
      end
      if (vecs[v].dsel == 1 && got_q.size() == 12) begin
        chk("plan_first_word", got_q[0], {2'b10, 16'hFFB3});
        chk("plan_last_word", got_q[11], {2'b01, 16'd54});
      end
      if (v == 3 && got_q.size() == 6) begin
        for (int i = 0; i < 6; i++) chk("tag_seq_3x2", got_q[i][17:16], tags32[i]);
      end
    end

    for (int r = 0; r < 10; r++) begin
      int len, rows;
      len  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      rows = $urandom_range(1, 4);
      fill_random(len * rows);
      run_job(len, rows, $urandom_range(0, 2), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    // Reset after four words have been written into the buffer.
    fill_plan();
    @(negedge clk);
    start = 1'b1; row_len = 8'd12; num_rows = 8'd1; IF_buff_ready = 1'b1;
    wr = 0;
    for (int c = 0; c < 40 && wr < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      src_valid = 1'b1;
      src_data = src_q[wr];
      #1;
      if (IF_buff_wen && IF_buff_ready) wr++;
    end
    chk("midjob_writes_reached", wr, 4);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midjob_reset_outputs", {src_ready, IF_buff_wen, IF_buff_clr, IFMap, busy, done}, 64'd0);
    @(negedge clk);
    src_valid = 1'b0;
    rstn = 1'b1;
    fill_random(12);
    run_job(12, 1, 0, 0, 1'b0);
    chk("post_reset_words", got_q.size(), 12);
    if (got_q.size() > 0) chk("post_reset_first_tag", got_q[0][17:16], 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
